// File: rtl/sobel_pkg.sv
// Shared types for the Sobel window sequencer.
//   PIX_W_DEFAULT : default pixel width used by the sequencer and its line buffer
//   state_t       : sequencer states
//   window_t      : 3x3 window bundle at the default pixel width, P0 top-left to
//                   P8 bottom-right, for datapath blocks that carry it as one value
package sobel_pkg;

  localparam int PIX_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic [PIX_W_DEFAULT-1:0] p0;
    logic [PIX_W_DEFAULT-1:0] p1;
    logic [PIX_W_DEFAULT-1:0] p2;
    logic [PIX_W_DEFAULT-1:0] p3;
    logic [PIX_W_DEFAULT-1:0] p4;
    logic [PIX_W_DEFAULT-1:0] p5;
    logic [PIX_W_DEFAULT-1:0] p6;
    logic [PIX_W_DEFAULT-1:0] p7;
    logic [PIX_W_DEFAULT-1:0] p8;
  } window_t;

endpackage

// File: rtl/sobel_line_buffer.sv
// Two-line pixel buffer, one entry per image column.
//   clk       : clock
//   we        : write strobe, one pixel per accepted input
//   addr      : column of the incoming pixel
//   wdata     : incoming pixel (row r)
//   rd_row_m1 : stored pixel of row r-1 at addr (combinational read)
//   rd_row_m2 : stored pixel of row r-2 at addr (combinational read)
// A write moves the row r-1 entry down to the r-2 line and stores the new pixel
// as the r-1 entry, so the read and the write of a column share one cycle.
// Contents are not reset; the first two lines of every frame rewrite them.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int PIX_W = PIX_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(IMG_W)-1:0] addr,
  input  logic [PIX_W-1:0]         wdata,
  output logic [PIX_W-1:0]         rd_row_m1,
  output logic [PIX_W-1:0]         rd_row_m2
);

  logic [PIX_W-1:0] line_m1 [IMG_W];
  logic [PIX_W-1:0] line_m2 [IMG_W];

  assign rd_row_m1 = line_m1[addr];
  assign rd_row_m2 = line_m2[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      line_m2[addr] <= line_m1[addr];
      line_m1[addr] <= wdata;
    end
  end

endmodule

// File: rtl/sobel_window_ctrl.sv
// Sobel window sequencer: turns a raster pixel stream into one 3x3 window per
// interior pixel for the gradient datapath.
//   clk, n_rst          : clock, asynchronous active-low reset
//   pix_valid/pix_ready : input pixel handshake; pix_sof marks pixel (0,0)
//   pix_data            : input pixel
//   P0..P8              : window, P0-P2 top row, P6-P8 bottom row, left to right
//   start_calculations  : window valid, held until win_ready
//   win_ready           : datapath takes the window this cycle
//   win_row, win_col    : coordinates of the window centre
//   frame_done          : one-cycle pulse after the last pixel of a frame
//   sync_err            : one-cycle pulse when pix_sof arrives mid-frame
//   busy                : high while a frame is being filled or streamed
module sobel_window_ctrl
  import sobel_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = PIX_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     pix_valid,
  input  logic                     pix_sof,
  input  logic [PIX_W-1:0]         pix_data,
  output logic                     pix_ready,
  output logic [PIX_W-1:0]         P0,
  output logic [PIX_W-1:0]         P1,
  output logic [PIX_W-1:0]         P2,
  output logic [PIX_W-1:0]         P3,
  output logic [PIX_W-1:0]         P4,
  output logic [PIX_W-1:0]         P5,
  output logic [PIX_W-1:0]         P6,
  output logic [PIX_W-1:0]         P7,
  output logic [PIX_W-1:0]         P8,
  output logic                     start_calculations,
  input  logic                     win_ready,
  output logic [$clog2(IMG_H)-1:0] win_row,
  output logic [$clog2(IMG_W)-1:0] win_col,
  output logic                     frame_done,
  output logic                     sync_err,
  output logic                     busy
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);

  state_t           state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  logic             accept;
  logic             in_frame;
  logic             lb_we;
  logic [COL_W-1:0] lb_addr;
  logic [PIX_W-1:0] lb_row_m1;
  logic [PIX_W-1:0] lb_row_m2;

  // win[0..8] map to P0..P8; each row is a 3-deep shift register
  logic [PIX_W-1:0] win [9];

  // A pending window blocks new pixels unless the datapath takes it this cycle,
  // which is what gives back-to-back windows with no bubble.
  assign pix_ready = (state != DONE) && (!start_calculations || win_ready);
  assign accept    = pix_valid && pix_ready;
  assign in_frame  = (state == FILL) || (state == STREAM);

  // Every pixel that belongs to a frame (including a restarting sof) is written
  // and shifted in; a sof pixel always lands in column 0.
  assign lb_we   = accept && (in_frame || pix_sof);
  assign lb_addr = pix_sof ? '0 : col;

  sobel_line_buffer #(
    .IMG_W (IMG_W),
    .PIX_W (PIX_W)
  ) u_line_buffer (
    .clk       (clk),
    .we        (lb_we),
    .addr      (lb_addr),
    .wdata     (pix_data),
    .rd_row_m1 (lb_row_m1),
    .rd_row_m2 (lb_row_m2)
  );

  // Window shift register: right column loads rows r-2, r-1, r at column c.
  // It only moves on an accepted pixel, so a stalled window stays frozen.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < 9; i++) win[i] <= '0;
    end else if (lb_we) begin
      win[0] <= win[1];
      win[1] <= win[2];
      win[2] <= lb_row_m2;
      win[3] <= win[4];
      win[4] <= win[5];
      win[5] <= lb_row_m1;
      win[6] <= win[7];
      win[7] <= win[8];
      win[8] <= pix_data;
    end
  end

  assign P0 = win[0];
  assign P1 = win[1];
  assign P2 = win[2];
  assign P3 = win[3];
  assign P4 = win[4];
  assign P5 = win[5];
  assign P6 = win[6];
  assign P7 = win[7];
  assign P8 = win[8];

  // Sequencer: position counters, window valid, status pulses.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state              <= IDLE;
      col                <= '0;
      row                <= '0;
      start_calculations <= 1'b0;
      win_row            <= '0;
      win_col            <= '0;
      frame_done         <= 1'b0;
      sync_err           <= 1'b0;
      busy               <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      if (win_ready) start_calculations <= 1'b0;

      case (state)
        IDLE: begin
          if (accept && pix_sof) begin
            row   <= '0;
            col   <= COL_W'(1);
            state <= FILL;
            busy  <= 1'b1;
          end
        end

        FILL, STREAM: begin
          if (accept) begin
            if (pix_sof) begin
              // Resync: drop whatever is pending and restart at (0,0)
              sync_err           <= 1'b1;
              start_calculations <= 1'b0;
              row                <= '0;
              col                <= COL_W'(1);
              state              <= FILL;
            end else begin
              // Columns 0 and 1 only refill the shift register after a wrap
              if ((state == STREAM) && (col >= COL_W'(2))) begin
                start_calculations <= 1'b1;
                win_row            <= row - 1'b1;
                win_col            <= col - 1'b1;
              end
              if (col == LAST_COL) begin
                col <= '0;
                if (row == LAST_ROW) begin
                  row        <= '0;
                  state      <= DONE;
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
                end else begin
                  row <= row + 1'b1;
                  if (row == ROW_W'(1)) state <= STREAM;
                end
              end else begin
                col <= col + 1'b1;
              end
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed bench for sobel_window_ctrl with a 5x4 image, pixel value row*5+col.
module tb_sobel_window_ctrl;

  localparam int IMG_W = 5;
  localparam int IMG_H = 4;
  localparam int PIX_W = 8;

  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic       pix_valid = 1'b0;
  logic       pix_sof = 1'b0;
  logic [7:0] pix_data = '0;
  logic       win_ready = 1'b1;

  logic       pix_ready;
  logic [7:0] P0, P1, P2, P3, P4, P5, P6, P7, P8;
  logic       start_calculations;
  logic [1:0] win_row;
  logic [2:0] win_col;
  logic       frame_done, sync_err, busy;

  sobel_window_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W)) dut (
    .clk(clk), .n_rst(n_rst), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_data(pix_data), .pix_ready(pix_ready),
    .P0(P0), .P1(P1), .P2(P2), .P3(P3), .P4(P4), .P5(P5), .P6(P6), .P7(P7), .P8(P8),
    .start_calculations(start_calculations), .win_ready(win_ready),
    .win_row(win_row), .win_col(win_col), .frame_done(frame_done),
    .sync_err(sync_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Expected windows of one frame: {triggering pixel index, P0..P8, centre row, centre col}
  typedef struct packed {
    logic [7:0]        trig;
    logic [0:8][7:0]   p;
    logic [1:0]        r;
    logic [2:0]        c;
  } win_rec_t;

  typedef struct packed {
    logic [0:8][7:0]   p;
    logic [1:0]        r;
    logic [2:0]        c;
  } cap_t;

  win_rec_t tbl [6];
  cap_t     capq [$];
  cap_t     cap_tmp;
  int       tests = 0;
  int       fails = 0;
  int       fd_cnt = 0;
  int       se_cnt = 0;

  // Record every window the datapath actually takes, and count status pulses
  always @(negedge clk) begin
    if (n_rst && start_calculations && win_ready) begin
      cap_tmp.p = {P0, P1, P2, P3, P4, P5, P6, P7, P8};
      cap_tmp.r = win_row;
      cap_tmp.c = win_col;
      capq.push_back(cap_tmp);
    end
    if (frame_done) fd_cnt++;
    if (sync_err) se_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic is_trig(input int idx);
    for (int i = 0; i < 6; i++) if (int'(tbl[i].trig) == idx) return 1'b1;
    return 1'b0;
  endfunction

  // Present one pixel and hold it until accepted (bounded); returns at edge+1
  task automatic send_pix(input logic [7:0] d, input logic sof);
    logic acc;
    acc = 1'b0;
    pix_valid = 1'b1;
    pix_sof   = sof;
    pix_data  = d;
    for (int t = 0; t < 40 && !acc; t++) begin
      @(negedge clk);
      acc = pix_ready;
      @(posedge clk);
      #1;
    end
    chk($sformatf("accepted_%0d", d), acc, 1);
    pix_sof = 1'b0;
  endtask

  // Full frame with sof on the first pixel, win_ready held high
  task automatic run_frame(input int off, input logic exp_sync);
    for (int idx = 0; idx < IMG_W * IMG_H; idx++) begin
      send_pix(8'(off + idx), idx == 0);
      if (idx == 0) begin
        chk("sync_err_on_sof", sync_err, exp_sync);
        chk("busy_after_sof", busy, 1);
      end
      chk($sformatf("start_after_pix%0d", idx), start_calculations, is_trig(idx));
    end
    chk("frame_done_pulse", frame_done, 1);
    chk("pix_ready_in_done", pix_ready, 0);
    chk("busy_in_done", busy, 0);
    pix_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("frame_done_cleared", frame_done, 0);
  endtask

  task automatic check_windows(input int off);
    chk("window_count", capq.size(), 6);
    for (int i = 0; i < 6 && i < capq.size(); i++) begin
      for (int k = 0; k < 9; k++)
        chk($sformatf("win%0d_P%0d", i, k), capq[i].p[k], 8'(tbl[i].p[k] + off));
      chk($sformatf("win%0d_row", i), capq[i].r, tbl[i].r);
      chk($sformatf("win%0d_col", i), capq[i].c, tbl[i].c);
    end
  endtask

  initial begin
    tbl[0] = '{8'd12, {8'd0, 8'd1, 8'd2, 8'd5, 8'd6, 8'd7, 8'd10, 8'd11, 8'd12}, 2'd1, 3'd1};
    tbl[1] = '{8'd13, {8'd1, 8'd2, 8'd3, 8'd6, 8'd7, 8'd8, 8'd11, 8'd12, 8'd13}, 2'd1, 3'd2};
    tbl[2] = '{8'd14, {8'd2, 8'd3, 8'd4, 8'd7, 8'd8, 8'd9, 8'd12, 8'd13, 8'd14}, 2'd1, 3'd3};
    tbl[3] = '{8'd17, {8'd5, 8'd6, 8'd7, 8'd10, 8'd11, 8'd12, 8'd15, 8'd16, 8'd17}, 2'd2, 3'd1};
    tbl[4] = '{8'd18, {8'd6, 8'd7, 8'd8, 8'd11, 8'd12, 8'd13, 8'd16, 8'd17, 8'd18}, 2'd2, 3'd2};
    tbl[5] = '{8'd19, {8'd7, 8'd8, 8'd9, 8'd12, 8'd13, 8'd14, 8'd17, 8'd18, 8'd19}, 2'd2, 3'd3};

    // 1. Reset state and IDLE dropping of non-sof pixels
    #2 n_rst = 1'b0;
    #10;
    chk("rst_start", start_calculations, 0);
    chk("rst_P4", P4, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_sync_err", sync_err, 0);
    chk("rst_pix_ready", pix_ready, 1);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_pix_ready", pix_ready, 1);
    chk("idle_win_row", win_row, 0);
    chk("idle_win_col", win_col, 0);
    chk("idle_P8", P8, 0);
    for (int i = 0; i < 3; i++) begin
      send_pix(8'(50 + i), 1'b0);
      chk("idle_nosof_start", start_calculations, 0);
      chk("idle_nosof_busy", busy, 0);
    end
    pix_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_no_windows", capq.size(), 0);

    // 2. Clean frame, no backpressure
    capq.delete();
    fd_cnt = 0;
    run_frame(0, 1'b0);
    check_windows(0);
    chk("frame_done_once", fd_cnt, 1);

    // 3. Backpressure on the first window
    capq.delete();
    for (int idx = 0; idx <= 12; idx++) send_pix(8'(idx), idx == 0);
    chk("bp_first_window", start_calculations, 1);
    win_ready = 1'b0;
    pix_valid = 1'b1;
    pix_data  = 8'd13;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk("bp_pix_ready", pix_ready, 0);
      chk("bp_start_held", start_calculations, 1);
      chk("bp_P4_held", P4, 6);
      chk("bp_P8_held", P8, 12);
      chk("bp_col_held", win_col, 1);
      @(posedge clk);
      #1;
    end
    win_ready = 1'b1;
    for (int idx = 13; idx < IMG_W * IMG_H; idx++) send_pix(8'(idx), 1'b0);
    pix_valid = 1'b0;
    @(posedge clk);
    #1;
    check_windows(0);

    // 4. Mid-frame sof on pixel 8 restarts with new data
    capq.delete();
    se_cnt = 0;
    fd_cnt = 0;
    for (int idx = 0; idx < 8; idx++) send_pix(8'(idx), idx == 0);
    run_frame(100, 1'b1);
    check_windows(100);
    chk("sync_err_once", se_cnt, 1);
    chk("resync_frame_done_once", fd_cnt, 1);

    // 5. Async reset during STREAM, then a clean frame
    for (int idx = 0; idx <= 13; idx++) send_pix(8'(idx), idx == 0);
    chk("pre_reset_start", start_calculations, 1);
    n_rst = 1'b0;
    pix_valid = 1'b0;
    #1;
    chk("async_rst_start", start_calculations, 0);
    chk("async_rst_P8", P8, 0);
    chk("async_rst_P4", P4, 0);
    chk("async_rst_row", win_row, 0);
    chk("async_rst_col", win_col, 0);
    chk("async_rst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    capq.delete();
    fd_cnt = 0;
    run_frame(0, 1'b0);
    check_windows(0);
    chk("post_reset_frame_done_once", fd_cnt, 1);

    // 6. Row wrap: no window for input columns 0 and 1
    for (int idx = 0; idx <= 14; idx++) send_pix(8'(idx), idx == 0);
    chk("wrap_win_pix14", start_calculations, 1);
    send_pix(8'd15, 1'b0);
    chk("wrap_no_win_pix15", start_calculations, 0);
    send_pix(8'd16, 1'b0);
    chk("wrap_no_win_pix16", start_calculations, 0);
    send_pix(8'd17, 1'b0);
    chk("wrap_win_pix17", start_calculations, 1);
    chk("wrap_pix17_row", win_row, 2);
    chk("wrap_pix17_col", win_col, 1);
    chk("wrap_pix17_P0", P0, 5);
    send_pix(8'd18, 1'b0);
    send_pix(8'd19, 1'b0);
    pix_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
